mips_mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle MIPS core. Serves the core's instruction-fetch port (PC/Instruction) and data port (Address/MemRead/MemWrite/Write_data/Read_data).
- Backs a word-addressed RAM.
- Provides a small MMIO page with a free-running cycle counter, a console TX FIFO with a valid/ready drain port, and a sticky halt register.
- Sits between the core and the testbench/top level.

---
 rtl/mips_mem_responder.sv | 148 ++++++++++++++
 tb/tb_mips_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multi-cycle MIPS core: word RAM for fetch and data,
// plus an MMIO page with a cycle counter, console TX FIFO and sticky halt register.
module mips_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic        mem_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [15:0] OFF_CYCLE  = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_HALT   = 16'h000C;

    logic [31:0] ram [2**ADDR_WIDTH];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic                  fetch_ok;
    logic [ADDR_WIDTH-1:0] fetch_index;
    logic                  is_mmio;
    logic                  is_ram;
    logic                  access;
    logic                  data_err;
    logic [15:0]           offset;
    logic [ADDR_WIDTH-1:0] data_index;
    logic                  ram_we;
    logic                  mmio_we;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  halt_set;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [31:0]           mmio_rdata;

    assign fetch_ok    = (PC[1:0] == 2'b00) && (PC[31:ADDR_WIDTH+2] == '0);
    assign fetch_index = PC[ADDR_WIDTH+1:2];
    assign Instruction = fetch_ok ? ram[fetch_index] : 32'h0;

    assign is_mmio    = (Address[31:16] == 16'hFFFF);
    assign is_ram     = (Address[31:ADDR_WIDTH+2] == '0);
    assign access     = MemRead || MemWrite;
    assign data_err   = access && ((Address[1:0] != 2'b00) || !(is_mmio || is_ram));
    assign offset     = Address[15:0];
    assign data_index = Address[ADDR_WIDTH+1:2];

    assign ram_we   = MemWrite && !data_err && is_ram;
    assign mmio_we  = MemWrite && !data_err && is_mmio;
    assign push_req = mmio_we && (offset == OFF_TXDATA);
    assign halt_set = mmio_we && (offset == OFF_HALT);

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign pop        = tx_valid && tx_ready;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!fifo_full || pop);

    always_comb begin
        mmio_rdata = 32'h0;
        case (offset)
            OFF_CYCLE:  mmio_rdata = cycle_count;
            OFF_STATUS: mmio_rdata = {16'h0, 8'(count), 5'b0, overflow, fifo_empty, fifo_full};
            OFF_HALT:   mmio_rdata = {31'b0, halted};
            default:    mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        Read_data = 32'h0;
        if (MemRead && !data_err) begin
            if (is_ram) begin
                Read_data = ram[data_index];
            end else if (is_mmio) begin
                Read_data = mmio_rdata;
            end
        end
    end

    // Storage arrays have no reset so a write coinciding with rst still commits.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[data_index] <= Write_data;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= Write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
            mem_err     <= 1'b0;
            cycle_count <= 32'h0;
        end else begin
            if (!halted) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (halt_set) begin
                halted <= 1'b1;
            end
            if (data_err || !fetch_ok) begin
                mem_err <= 1'b1;
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: driver keeps a queue/array reference model,
// a negedge monitor pops expected reads and TX bytes and compares DUT outputs.
module tb_mips_mem_responder;
    localparam int AW        = 10;
    localparam int DEPTH     = 4;
    localparam int RAM_WORDS = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;
    logic [31:0] cycle_count;
    logic        mem_err;

    always #5 clk = ~clk;

    mips_mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .PC(PC), .Instruction(Instruction),
        .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Read_data(Read_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halted(halted), .cycle_count(cycle_count), .mem_err(mem_err)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [7:0]  tx_q[$];
    int          tests = 0;
    int          fails = 0;

    logic [31:0] m_ram [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [7:0]  m_fifo[$];
    bit          m_over;
    bit          m_halt;
    bit          m_err;
    logic [31:0] m_cycle;
    bit          m_state_known = 1'b0;
    bit          flush_pending = 1'b0;

    bit          armed = 1'b0;
    bit          e_instr_chk;
    logic [31:0] e_instr;
    bit          e_tx_valid;
    bit          e_halt;
    bit          e_err;
    logic [31:0] e_cycle;

    logic [31:0] g_pc = 32'h0;
    bit          g_rdy = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (e_instr_chk) checkOutput("instruction", Instruction, e_instr);
            checkOutput("tx_valid", 32'(tx_valid), 32'(e_tx_valid));
            checkOutput("halted", 32'(halted), 32'(e_halt));
            checkOutput("mem_err", 32'(mem_err), 32'(e_err));
            checkOutput("cycle_count", cycle_count, e_cycle);
            if (MemRead) begin
                if (rd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL read_data: no expectation queued, got %h at %0t", Read_data, $time);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    if (e.chk) checkOutput("read_data", Read_data, e.data);
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL tx_data: unexpected byte %h, expected none at %0t", tx_data, $time);
                end else begin
                    checkOutput("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input bit r, input logic [31:0] pc_i, input logic [31:0] addr,
                                 input bit rd, input bit wr, input logic [31:0] wd, input bit rdy);
        bit          fetch_ok;
        bit          is_mmio;
        bit          is_ram;
        bit          derr;
        bit          pop;
        bit          mmio_wr;
        logic [15:0] off;
        int          idx;
        int          pidx;
        rd_exp_t     e;
        if (flush_pending) begin
            tx_q.delete();
            flush_pending = 1'b0;
        end
        rst        = r;
        PC         = pc_i;
        Address    = addr;
        MemRead    = rd;
        MemWrite   = wr;
        Write_data = wd;
        tx_ready   = rdy;

        fetch_ok = (pc_i[1:0] == 2'b00) && (pc_i < 32'(RAM_WORDS * 4));
        is_mmio  = (addr[31:16] == 16'hFFFF);
        is_ram   = (addr < 32'(RAM_WORDS * 4));
        derr     = (rd || wr) && ((addr[1:0] != 2'b00) || !(is_mmio || is_ram));
        off      = addr[15:0];
        idx      = int'(addr[AW+1:2]);
        pidx     = int'(pc_i[AW+1:2]);
        mmio_wr  = wr && !derr && is_mmio;

        armed = m_state_known;
        if (m_state_known) begin
            e_instr_chk = !fetch_ok || m_known[pidx];
            e_instr     = fetch_ok ? m_ram[pidx] : 32'h0;
            e_tx_valid  = (m_fifo.size() != 0);
            e_halt      = m_halt;
            e_err       = m_err;
            e_cycle     = m_cycle;
            if (rd) begin
                e.data = 32'h0;
                e.chk  = 1'b1;
                if (!derr && is_ram) begin
                    e.data = m_ram[idx];
                    e.chk  = m_known[idx];
                end else if (!derr && is_mmio) begin
                    case (off)
                        16'h0000: e.data = m_cycle;
                        16'h0008: e.data = {16'h0, 8'(m_fifo.size()), 5'b0, m_over,
                                            m_fifo.size() == 0, m_fifo.size() == DEPTH};
                        16'h000C: e.data = {31'b0, m_halt};
                        default:  e.data = 32'h0;
                    endcase
                end
                rd_q.push_back(e);
            end
        end

        if (wr && !derr && is_ram) begin
            m_ram[idx]   = wd;
            m_known[idx] = 1'b1;
        end
        if (r) begin
            m_fifo.delete();
            m_over        = 1'b0;
            m_halt        = 1'b0;
            m_err         = 1'b0;
            m_cycle       = 32'h0;
            m_state_known = 1'b1;
            flush_pending = 1'b1;
        end else if (m_state_known) begin
            pop = (m_fifo.size() != 0) && rdy;
            if (!fetch_ok || derr) m_err = 1'b1;
            if (!m_halt) m_cycle = m_cycle + 32'd1;
            if (mmio_wr && off == 16'h000C) m_halt = 1'b1;
            if (pop) void'(m_fifo.pop_front());
            if (mmio_wr && off == 16'h0004) begin
                if (m_fifo.size() < DEPTH) begin
                    m_fifo.push_back(wd[7:0]);
                    tx_q.push_back(wd[7:0]);
                end else begin
                    m_over = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, g_pc, 32'h0, 1'b0, 1'b0, 32'h0, g_rdy);
    endtask

    task automatic wrMem(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b0, g_pc, a, 1'b0, 1'b1, d, g_rdy);
    endtask

    task automatic rdMem(input logic [31:0] a);
        applyStimulus(1'b0, g_pc, a, 1'b1, 1'b0, 32'h0, g_rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, g_pc, 32'h0, 1'b0, 1'b0, 32'h0, g_rdy);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] pc_r;
        int          kind;
        bit          r;
        bit          rd;
        bit          wr;

        rst = 1'b1; PC = 32'h0; Address = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
        Write_data = 32'h0; tx_ready = 1'b0;
        @(posedge clk);
        #1;
        doReset();
        doReset();

        // RAM round-trip, fetch, and same-cycle write+read
        wrMem(32'h10, 32'hDEADBEEF);
        rdMem(32'h10);
        g_pc = 32'h10;
        idle(1);
        applyStimulus(1'b0, g_pc, 32'h10, 1'b1, 1'b1, 32'h1, g_rdy);
        rdMem(32'h10);

        // Error handling
        wrMem(32'h12, 32'h55);
        rdMem(32'h10);
        rdMem(32'h0010_0000);
        rdMem(32'h0000_0011);
        idle(2);
        doReset();
        idle(1);

        // FIFO fill and overflow, then drain
        g_rdy = 1'b0;
        for (int b = 8'h41; b <= 8'h45; b++) wrMem(32'hFFFF0004, 32'(b));
        rdMem(32'hFFFF0008);
        g_rdy = 1'b1;
        idle(5);
        rdMem(32'hFFFF0008);

        // Full FIFO with simultaneous pop and push
        doReset();
        g_rdy = 1'b0;
        for (int b = 1; b <= 4; b++) wrMem(32'hFFFF0004, 32'(8'h60 + b));
        g_rdy = 1'b1;
        wrMem(32'hFFFF0004, 32'h5A);
        rdMem(32'hFFFF0008);
        idle(6);
        rdMem(32'hFFFF0008);

        // Cycle counter and halt
        doReset();
        idle(3);
        rdMem(32'hFFFF0000);
        wrMem(32'hFFFF000C, 32'h0);
        idle(3);
        rdMem(32'hFFFF000C);
        rdMem(32'hFFFF0000);
        rdMem(32'hFFFF0040);
        doReset();
        idle(1);

        // Reset mid-drain, with a RAM write coinciding with reset
        g_rdy = 1'b0;
        for (int b = 1; b <= 3; b++) wrMem(32'hFFFF0004, 32'(8'h70 + b));
        g_rdy = 1'b1;
        idle(1);
        applyStimulus(1'b1, g_pc, 32'h20, 1'b0, 1'b1, 32'hCAFE0001, g_rdy);
        rdMem(32'hFFFF0008);
        rdMem(32'h10);
        rdMem(32'h20);

        // Randomized traffic over a small RAM window and the MMIO page
        for (int w = 0; w < 16; w++) wrMem(32'(w * 4), $urandom);
        for (int i = 0; i < 800; i++) begin
            kind = int'($urandom_range(0, 99));
            r    = (kind == 0);
            pc_r = (kind == 1) ? 32'h0000_0002 : {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2: addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                3, 4, 5: addr = 32'hFFFF0004;
                6:       addr = 32'hFFFF0008;
                7:       addr = 32'hFFFF0000;
                8: begin
                    addr = 32'hFFFF000C;
                    if ($urandom_range(0, 9) != 0) wr = 1'b0;
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0:       addr = 32'hFFFF0000 | 32'({$urandom_range(5, 255), 2'b00});
                        1:       addr = 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
                        2:       addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                        default: addr = 32'hFFFF0004 | 32'($urandom_range(1, 3));
                    endcase
                    if ($urandom_range(0, 3) != 0) begin
                        rd = 1'b0;
                        wr = 1'b0;
                    end
                end
            endcase
            applyStimulus(r, pc_r, addr, rd, wr, $urandom, 1'($urandom_range(0, 1)));
        end
        g_pc = 32'h0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
